// File: rtl/alu_uart_tx_interface.sv
// ALU result to UART TX bridge.
// Each ALU result is sent as two UART frames: the result byte, then a status
// byte {zeros, carry, zero}. Results are held in a two-entry buffer: CUR is
// the entry being sent and PEND is the next one. A result arriving while both
// are full is dropped and flagged on the sticky o_overflow output.
//
// Handshake: i_result_valid is a one-cycle strobe qualifying i_result,
// i_carry and i_zero (no backpressure; overflow flags drops). o_tx_start
// requests one frame with o_tx_data for exactly one cycle. The transmitter
// answers with a one-cycle i_tx_done pulse, which is only honoured while
// waiting for that frame. i_tx_busy high holds off the start of a new result.
// o_state exposes the FSM state for debug visibility.
module alu_uart_tx_interface #(
    parameter int NB_DATA = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_result,
    input  logic               i_carry,
    input  logic               i_zero,
    input  logic               i_result_valid,
    input  logic               i_tx_busy,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_overflow,
    output logic [2:0]         o_state
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND_RES  = 3'd1,
        ST_WAIT_RES  = 3'd2,
        ST_SEND_STAT = 3'd3,
        ST_WAIT_STAT = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic                 cur_valid_q, cur_valid_d;
    logic [NB_DATA-1:0]   cur_result_q, cur_result_d;
    logic                 cur_carry_q, cur_carry_d;
    logic                 cur_zero_q, cur_zero_d;
    logic                 pend_valid_q, pend_valid_d;
    logic [NB_DATA-1:0]   pend_result_q, pend_result_d;
    logic                 pend_carry_q, pend_carry_d;
    logic                 pend_zero_q, pend_zero_d;
    logic [NB_DATA-1:0]   tx_data_q, tx_data_d;
    logic                 tx_start_q, tx_start_d;
    logic                 busy_q, busy_d;
    logic                 overflow_q, overflow_d;

    logic                 release_cur;
    logic [NB_DATA-1:0]   status_byte;

    // Buffer management: retire CUR after its status frame, then place any new result.
    always_comb begin
        cur_valid_d   = cur_valid_q;
        cur_result_d  = cur_result_q;
        cur_carry_d   = cur_carry_q;
        cur_zero_d    = cur_zero_q;
        pend_valid_d  = pend_valid_q;
        pend_result_d = pend_result_q;
        pend_carry_d  = pend_carry_q;
        pend_zero_d   = pend_zero_q;
        overflow_d    = overflow_q;

        release_cur = (state_q == ST_WAIT_STAT) && i_tx_done;

        if (release_cur) begin
            cur_valid_d  = pend_valid_q;
            cur_result_d = pend_result_q;
            cur_carry_d  = pend_carry_q;
            cur_zero_d   = pend_zero_q;
            pend_valid_d = 1'b0;
        end

        if (i_result_valid) begin
            if (release_cur) begin
                // CUR frees up this edge, so there is always room for the new result.
                if (pend_valid_q) begin
                    pend_valid_d  = 1'b1;
                    pend_result_d = i_result;
                    pend_carry_d  = i_carry;
                    pend_zero_d   = i_zero;
                end else begin
                    cur_valid_d  = 1'b1;
                    cur_result_d = i_result;
                    cur_carry_d  = i_carry;
                    cur_zero_d   = i_zero;
                end
            end else if (!cur_valid_q) begin
                cur_valid_d  = 1'b1;
                cur_result_d = i_result;
                cur_carry_d  = i_carry;
                cur_zero_d   = i_zero;
            end else if (!pend_valid_q) begin
                pend_valid_d  = 1'b1;
                pend_result_d = i_result;
                pend_carry_d  = i_carry;
                pend_zero_d   = i_zero;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    // Frame sequencing: result byte, wait for done, status byte, wait for done.
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;

        status_byte    = '0;
        status_byte[1] = cur_carry_q;
        status_byte[0] = cur_zero_q;

        case (state_q)
            ST_IDLE: begin
                if (cur_valid_q && !i_tx_busy) begin
                    state_d   = ST_SEND_RES;
                    tx_data_d = cur_result_q;
                end
            end
            ST_SEND_RES:  state_d = ST_WAIT_RES;
            ST_WAIT_RES: begin
                if (i_tx_done) begin
                    state_d   = ST_SEND_STAT;
                    tx_data_d = status_byte;
                end
            end
            ST_SEND_STAT: state_d = ST_WAIT_STAT;
            ST_WAIT_STAT: begin
                if (i_tx_done) begin
                    state_d = ST_IDLE;
                end
            end
            default:      state_d = ST_IDLE;
        endcase

        tx_start_d = (state_d == ST_SEND_RES) || (state_d == ST_SEND_STAT);
        busy_d     = cur_valid_d || (state_d != ST_IDLE);
    end

    // State, buffer and registered outputs; synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q       <= ST_IDLE;
            cur_valid_q   <= 1'b0;
            cur_result_q  <= '0;
            cur_carry_q   <= 1'b0;
            cur_zero_q    <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_result_q <= '0;
            pend_carry_q  <= 1'b0;
            pend_zero_q   <= 1'b0;
            tx_data_q     <= '0;
            tx_start_q    <= 1'b0;
            busy_q        <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_valid_q   <= cur_valid_d;
            cur_result_q  <= cur_result_d;
            cur_carry_q   <= cur_carry_d;
            cur_zero_q    <= cur_zero_d;
            pend_valid_q  <= pend_valid_d;
            pend_result_q <= pend_result_d;
            pend_carry_q  <= pend_carry_d;
            pend_zero_q   <= pend_zero_d;
            tx_data_q     <= tx_data_d;
            tx_start_q    <= tx_start_d;
            busy_q        <= busy_d;
            overflow_q    <= overflow_d;
        end
    end

    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_busy     = busy_q;
    assign o_overflow = overflow_q;
    assign o_state    = state_q;

endmodule

// File: doc/alu_uart_tx_interface.md
ALU_UART_TX_INTERFACE -- requirements
Module: alu_uart_tx_interface

Interface
REQ-001 Parameter NB_DATA, default 8, width of the ALU result and of each UART TX byte.
REQ-002 i_clk  input  1  system clock; all logic on the rising edge.
REQ-003 i_reset  input  1  reset, synchronous and active-low (0 = reset); sampled only on the i_clk rising edge.
REQ-004 i_result  input  NB_DATA  ALU result.
REQ-005 i_carry  input  1  ALU carry flag, qualified by i_result_valid.
REQ-006 i_zero  input  1  ALU zero flag, qualified by i_result_valid.
REQ-007 i_result_valid  input  1  one-cycle strobe: i_result, i_carry and i_zero are valid this cycle.
REQ-008 i_tx_busy  input  1  UART transmitter is shifting a frame.
REQ-009 i_tx_done  input  1  one-cycle pulse: UART transmitter finished a frame.
REQ-010 o_tx_data  output  NB_DATA  byte for the UART transmitter.
REQ-011 o_tx_start  output  1  one-cycle request to transmit o_tx_data.
REQ-012 o_busy  output  1  a result is buffered or being transmitted.
REQ-013 o_overflow  output  1  sticky: a result was dropped.

Function
REQ-014 Each result SHALL be sent as two UART frames, in order: byte 0 = result; byte 1 = status {(NB_DATA-2) zeros, carry, zero} (bit0 = zero, bit1 = carry).
REQ-015 Two-entry buffer: CUR (entry being sent) and PEND (next entry); each entry holds result, carry and zero plus a valid bit.
REQ-016 i_result_valid with CUR empty -> capture into CUR at that edge.
REQ-017 i_result_valid with CUR full and PEND empty -> capture into PEND.
REQ-018 i_result_valid with CUR and PEND both full -> drop the result; o_overflow set to 1 and held until reset; CUR and PEND unchanged.
REQ-019 FSM states: IDLE, SEND_RES, WAIT_RES, SEND_STAT, WAIT_STAT; all state and outputs registered.
REQ-020 IDLE -> SEND_RES when CUR valid and i_tx_busy=0; o_tx_data loaded with CUR result on that edge; otherwise stay in IDLE.
REQ-021 SEND_RES -> WAIT_RES unconditionally; o_tx_start=1 only while in SEND_RES or SEND_STAT (exactly one cycle per frame).
REQ-022 WAIT_RES -> SEND_STAT on i_tx_done=1, loading o_tx_data with the status byte; otherwise hold.
REQ-023 SEND_STAT -> WAIT_STAT unconditionally.
REQ-024 WAIT_STAT -> IDLE on i_tx_done=1; on that edge CUR takes PEND (valid or empty) and PEND clears.
REQ-025 Simultaneous i_result_valid and the WAIT_STAT i_tx_done edge: with PEND full, new data -> PEND and old PEND -> CUR; with PEND empty, new data -> CUR directly; no drop, o_overflow unchanged.
REQ-026 i_tx_done SHALL be ignored in IDLE, SEND_RES and SEND_STAT.
REQ-027 o_tx_data SHALL stay stable from its load edge until the next load.
REQ-028 Latency: i_result_valid sampled at edge k into empty CUR in IDLE with i_tx_busy=0 -> o_tx_start high in the cycle after edge k+1.
REQ-029 o_busy = CUR valid OR state != IDLE (registered-equivalent, no combinational path from inputs).
REQ-030 Back-to-back results SHALL be transmitted in arrival order with no byte reordering.

Reset
REQ-031 i_reset=0 at an edge: state IDLE; CUR and PEND invalid; o_tx_data=0, o_tx_start=0, o_busy=0, o_overflow=0.
REQ-032 Reset mid-transfer SHALL abort: no further o_tx_start, buffered results discarded; a frame already in the UART is not this block's concern.
REQ-033 Inputs SHALL be ignored while i_reset=0.

Verification
REQ-034 Single result: result=0xA5, carry=1, zero=0, i_tx_busy=0 -> o_tx_start with 0xA5, then after i_tx_done, o_tx_start with 0x02; then IDLE, o_busy=0.
REQ-035 Zero result: result=0x00, carry=0, zero=1 -> frames 0x00 then 0x01.
REQ-036 Three results 0x11, 0x22, 0x33 strobed on consecutive cycles while idle -> frames 0x11, st, 0x22, st; 0x33 dropped; o_overflow=1 until reset.
REQ-037 i_tx_busy=1 held 20 cycles with CUR valid -> no o_tx_start until the cycle after i_tx_busy falls plus one edge.
REQ-038 New result 0x44 strobed on the same edge as the WAIT_STAT i_tx_done of 0x10, PEND empty -> 0x44 sent next; o_overflow stays 0.
REQ-039 i_reset=0 asserted in WAIT_RES with PEND full -> all outputs return to reset values; after release, no frame is sent without a new i_result_valid.
